cipher_job_ctrl: RTL and testbench

CIPHER_JOB_CTRL -- requirements
Module: cipher_job_ctrl

---
 rtl/cipher_job_ctrl.sv | 114 +++++++++++
 tb/tb_cipher_job_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_job_ctrl.sv
// cipher_job_ctrl: per-channel start/finish/timeout sequencing
// between PS request toggles and the cipher cores.
module cipher_job_ctrl #(
   parameter int NUM_CH  = 2,
   parameter int TIMEOUT = 1000,
   parameter int TO_W    = 16,
   parameter int CNT_W   = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NUM_CH-1:0]   req_tgl,
   input  logic [4*NUM_CH-1:0] cfg_in,
   input  logic [NUM_CH-1:0]   finish,
   input  logic [NUM_CH-1:0]   err_clr,
   output logic [NUM_CH-1:0]   start,
   output logic [4*NUM_CH-1:0] cfg_out,
   output logic [NUM_CH-1:0]   ack_tgl,
   output logic [NUM_CH-1:0]   busy,
   output logic [NUM_CH-1:0]   abort,
   output logic [NUM_CH-1:0]   timeout_err,
   output logic [CNT_W-1:0]    done_cnt,
   output logic                ready_led,
   output logic                err_led
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

   state_t            state     [NUM_CH];
   state_t            state_nxt [NUM_CH];
   logic [TO_W-1:0]   timer     [NUM_CH];
   logic [NUM_CH-1:0] req_lat;
   logic [NUM_CH-1:0] go;
   logic [NUM_CH-1:0] fin_ok;
   logic [NUM_CH-1:0] tmo;
   logic [CNT_W-1:0]  fin_cnt;

   always_ff @(posedge CLK) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (RST) state[i] <= IDLE;
         else     state[i] <= state_nxt[i];
      end
   end

   always_comb begin
      go      = '0;
      fin_ok  = '0;
      tmo     = '0;
      fin_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_nxt[i] = state[i];
         unique case (state[i])
            IDLE: begin
               if (req_tgl[i] != ack_tgl[i] && !timeout_err[i]) begin
                  go[i]        = 1'b1;
                  state_nxt[i] = START;
               end
            end
            START: state_nxt[i] = BUSY;
            BUSY: begin
               // finish takes priority over an expiring timer
               if (finish[i]) begin
                  fin_ok[i]    = 1'b1;
                  state_nxt[i] = IDLE;
               end else if (TIMEOUT != 0 && timer[i] == TO_LAST) begin
                  tmo[i]       = 1'b1;
                  state_nxt[i] = IDLE;
               end
            end
            default: state_nxt[i] = IDLE;
         endcase
         fin_cnt = fin_cnt + CNT_W'(fin_ok[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         start       <= '0;
         busy        <= '0;
         abort       <= '0;
         ack_tgl     <= '0;
         timeout_err <= '0;
         cfg_out     <= '0;
         req_lat     <= '0;
         done_cnt    <= '0;
         for (int i = 0; i < NUM_CH; i++) timer[i] <= '0;
      end else begin
         start       <= go;
         abort       <= tmo;
         timeout_err <= (timeout_err & ~err_clr) | tmo;
         done_cnt    <= done_cnt + fin_cnt;
         for (int i = 0; i < NUM_CH; i++) begin
            busy[i] <= (state_nxt[i] != IDLE);
            if (go[i]) begin
               cfg_out[4*i +: 4] <= cfg_in[4*i +: 4];
               req_lat[i]        <= req_tgl[i];
            end
            if (fin_ok[i] || tmo[i]) ack_tgl[i] <= req_lat[i];
            if (state[i] == START)     timer[i] <= '0;
            else if (state[i] == BUSY) timer[i] <= timer[i] + TO_W'(1);
         end
      end
   end

   assign ready_led = !RST && (busy == '0);
   assign err_led   = |timeout_err;

endmodule

// File: tb/tb_cipher_job_ctrl.sv
// tb_cipher_job_ctrl: directed and random checks of cipher_job_ctrl
// against a job-age reference model.
module tb_cipher_job_ctrl;

   localparam int TMO = 50;

   logic       CLK;
   logic       RST;
   logic [1:0] req_tgl;
   logic [7:0] cfg_in;
   logic [1:0] finish;
   logic [1:0] err_clr;
   logic [1:0] start;
   logic [7:0] cfg_out;
   logic [1:0] ack_tgl;
   logic [1:0] busy;
   logic [1:0] abort;
   logic [1:0] timeout_err;
   logic [3:0] done_cnt;
   logic       ready_led;
   logic       err_led;

   int chk = 0;
   int errs = 0;

   cipher_job_ctrl #(
      .NUM_CH(2), .TIMEOUT(TMO), .TO_W(16), .CNT_W(4)
   ) dut (
      .CLK(CLK), .RST(RST), .req_tgl(req_tgl), .cfg_in(cfg_in),
      .finish(finish), .err_clr(err_clr), .start(start),
      .cfg_out(cfg_out), .ack_tgl(ack_tgl), .busy(busy),
      .abort(abort), .timeout_err(timeout_err),
      .done_cnt(done_cnt), .ready_led(ready_led), .err_led(err_led)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // model: age -1 idle, 0 start cycle, k>=1 is the k-th busy cycle
   int         age   [2] = '{-1, -1};
   bit         m_ack [2];
   bit         m_err [2];
   bit         m_lat [2];
   bit         m_abt [2];
   logic [3:0] m_cfg [2] = '{4'd0, 4'd0};
   logic [3:0] m_cnt = 4'd0;

   function automatic void model_update();
      if (RST) begin
         for (int c = 0; c < 2; c++) begin
            age[c] = -1; m_ack[c] = 0; m_err[c] = 0;
            m_lat[c] = 0; m_abt[c] = 0; m_cfg[c] = 4'd0;
         end
         m_cnt = 4'd0;
         return;
      end
      for (int c = 0; c < 2; c++) begin
         bit e;
         e = m_err[c] & ~err_clr[c];
         m_abt[c] = 0;
         if (age[c] < 0) begin
            if (req_tgl[c] != m_ack[c] && !m_err[c]) begin
               age[c] = 0;
               m_cfg[c] = cfg_in[4*c +: 4];
               m_lat[c] = req_tgl[c];
            end
         end else if (age[c] == 0) begin
            age[c] = 1;
         end else if (finish[c]) begin
            age[c] = -1; m_ack[c] = m_lat[c]; m_cnt = m_cnt + 4'd1;
         end else if (age[c] == TMO) begin
            age[c] = -1; m_ack[c] = m_lat[c]; m_abt[c] = 1; e = 1;
         end else begin
            age[c] = age[c] + 1;
         end
         m_err[c] = e;
      end
   endfunction

   function automatic logic [23:0] exp_vec();
      logic [1:0] s, b, a, k, r;
      logic [7:0] cf;
      for (int c = 0; c < 2; c++) begin
         s[c] = (age[c] == 0);
         b[c] = (age[c] >= 0);
         a[c] = m_abt[c];
         k[c] = m_ack[c];
         r[c] = m_err[c];
         cf[4*c +: 4] = m_cfg[c];
      end
      return {s, b, a, k, r, cf, m_cnt, (!RST && b == 2'b00), (r != 2'b00)};
   endfunction

   function automatic logic [23:0] obs();
      return {start, busy, abort, ack_tgl, timeout_err, cfg_out,
              done_cnt, ready_led, err_led};
   endfunction

   task automatic step();
      @(posedge CLK);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      RST = 1; req_tgl = 0; cfg_in = 0; finish = 0; err_clr = 0;
      step(); step();
      chk++;
      if (obs() !== exp_vec()) begin
         errs++; $display("FAIL reset_vec got %h exp %h", obs(), exp_vec());
      end
      chk++;
      if (done_cnt !== 4'd0 || start !== 2'b00 || ready_led !== 1'b0) begin
         errs++;
         $display("FAIL reset_const got cnt=%h st=%b rdy=%b exp 0 00 0",
                  done_cnt, start, ready_led);
      end
      RST = 0;
      step();
      chk++;
      if (ready_led !== 1'b1) begin
         errs++; $display("FAIL ready_idle got %b exp 1", ready_led);
      end
   endtask

   task automatic test_basic();
      req_tgl[0] = 1; cfg_in[3:0] = 4'b1010;
      step();
      chk++;
      if (start[0] !== 1'b1 || cfg_out[3:0] !== 4'b1010) begin
         errs++;
         $display("FAIL basic_start got st=%b cfg=%b exp 1 1010",
                  start[0], cfg_out[3:0]);
      end
      cfg_in = 8'h55;
      step();
      chk++;
      if (start[0] !== 1'b0 || busy[0] !== 1'b1 || cfg_out[3:0] !== 4'b1010) begin
         errs++;
         $display("FAIL basic_hold got st=%b bz=%b cfg=%b exp 0 1 1010",
                  start[0], busy[0], cfg_out[3:0]);
      end
      repeat (18) begin
         step();
         chk++;
         if (obs() !== exp_vec()) begin
            errs++; $display("FAIL basic_run got %h exp %h", obs(), exp_vec());
         end
      end
      finish[0] = 1;
      step();
      finish[0] = 0;
      chk++;
      if (ack_tgl[0] !== 1'b1 || done_cnt !== 4'd1 || busy[0] !== 1'b0) begin
         errs++;
         $display("FAIL basic_done got ack=%b cnt=%h bz=%b exp 1 1 0",
                  ack_tgl[0], done_cnt, busy[0]);
      end
   endtask

   task automatic test_timeout();
      int na, nb, ns;
      na = 0; nb = 0; ns = 0;
      req_tgl[0] = ~req_tgl[0];
      repeat (60) begin
         step();
         if (abort[0]) na++;
         if (busy[0]) nb++;
         chk++;
         if (obs() !== exp_vec()) begin
            errs++; $display("FAIL tmo_run got %h exp %h", obs(), exp_vec());
         end
      end
      chk++;
      if (na != 1 || nb != TMO + 1 || timeout_err[0] !== 1'b1
          || ack_tgl[0] !== req_tgl[0] || err_led !== 1'b1) begin
         errs++;
         $display("FAIL tmo_result got ab=%0d bz=%0d err=%b ack=%b exp 1 %0d 1 %b",
                  na, nb, timeout_err[0], ack_tgl[0], TMO + 1, req_tgl[0]);
      end
      req_tgl[0] = ~req_tgl[0];
      repeat (5) begin
         step();
         if (start[0]) ns++;
      end
      chk++;
      if (ns != 0) begin
         errs++; $display("FAIL tmo_blocked got starts=%0d exp 0", ns);
      end
      err_clr[0] = 1;
      step();
      err_clr[0] = 0;
      chk++;
      if (timeout_err[0] !== 1'b0 || start[0] !== 1'b0) begin
         errs++;
         $display("FAIL tmo_clr got err=%b st=%b exp 0 0", timeout_err[0], start[0]);
      end
      step();
      chk++;
      if (start[0] !== 1'b1) begin
         errs++; $display("FAIL tmo_restart got %b exp 1", start[0]);
      end
      repeat (3) step();
      finish[0] = 1;
      step();
      finish[0] = 0;
      chk++;
      if (obs() !== exp_vec()) begin
         errs++; $display("FAIL tmo_fin got %h exp %h", obs(), exp_vec());
      end
   endtask

   task automatic test_both_finish();
      logic [3:0] c0;
      req_tgl = ~req_tgl;
      repeat (5) step();
      c0 = m_cnt;
      finish = 2'b11;
      step();
      finish = 2'b00;
      chk++;
      if (done_cnt !== c0 + 4'd2 || busy !== 2'b00) begin
         errs++;
         $display("FAIL both_fin got cnt=%h bz=%b exp %h 00",
                  done_cnt, busy, c0 + 4'd2);
      end
      req_tgl[0] = ~req_tgl[0];
      step();
      for (int k = 0; k < 60 && age[0] != TMO; k++) begin
         step();
         chk++;
         if (obs() !== exp_vec()) begin
            errs++; $display("FAIL edge_run got %h exp %h", obs(), exp_vec());
         end
      end
      c0 = m_cnt;
      finish[0] = 1;
      step();
      finish[0] = 0;
      chk++;
      if (abort[0] !== 1'b0 || timeout_err[0] !== 1'b0
          || done_cnt !== c0 + 4'd1 || busy[0] !== 1'b0) begin
         errs++;
         $display("FAIL fin_vs_tmo got ab=%b err=%b cnt=%h bz=%b exp 0 0 %h 0",
                  abort[0], timeout_err[0], done_cnt, busy[0], c0 + 4'd1);
      end
   endtask

   task automatic test_back_to_back();
      int ns;
      ns = 0;
      req_tgl[0] = ~req_tgl[0];
      repeat (4) step();
      req_tgl[0] = ~req_tgl[0];
      step();
      req_tgl[0] = ~req_tgl[0];
      repeat (3) step();
      finish[0] = 1;
      step();
      finish[0] = 0;
      repeat (5) begin
         step();
         if (start[0]) ns++;
      end
      chk++;
      if (ns != 0 || ack_tgl[0] !== req_tgl[0]) begin
         errs++;
         $display("FAIL b2b_even got starts=%0d ack=%b exp 0 %b",
                  ns, ack_tgl[0], req_tgl[0]);
      end
      req_tgl[0] = ~req_tgl[0];
      repeat (4) step();
      req_tgl[0] = ~req_tgl[0];
      repeat (2) step();
      finish[0] = 1;
      step();
      finish[0] = 0;
      repeat (3) begin
         step();
         if (start[0]) ns++;
         chk++;
         if (obs() !== exp_vec()) begin
            errs++; $display("FAIL b2b_run got %h exp %h", obs(), exp_vec());
         end
      end
      chk++;
      if (ns != 1) begin
         errs++; $display("FAIL b2b_odd got starts=%0d exp 1", ns);
      end
      repeat (2) step();
      finish[0] = 1;
      step();
      finish[0] = 0;
   endtask

   task automatic test_rst_mid();
      req_tgl = 2'b01;
      step();
      repeat (5) step();
      RST = 1; finish = 2'b11; err_clr = 2'b11;
      step();
      chk++;
      if (obs() !== exp_vec() || done_cnt !== 4'd0 || abort !== 2'b00
          || busy !== 2'b00 || ack_tgl !== 2'b00) begin
         errs++;
         $display("FAIL rst_mid got %h exp %h", obs(), exp_vec());
      end
      finish = 0; err_clr = 0;
      step();
      RST = 0;
      step();
      chk++;
      if (start !== 2'b01) begin
         errs++; $display("FAIL rst_release got %b exp 01", start);
      end
      repeat (2) step();
      finish[0] = 1;
      step();
      finish[0] = 0;
      chk++;
      if (done_cnt !== 4'd1 || ack_tgl !== 2'b01) begin
         errs++;
         $display("FAIL rst_job got cnt=%h ack=%b exp 1 01", done_cnt, ack_tgl);
      end
   endtask

   task automatic test_wrap();
      RST = 1; req_tgl = 0;
      step();
      RST = 0;
      step();
      repeat (17) begin
         req_tgl[1] = ~req_tgl[1];
         repeat (2) step();
         finish[1] = 1;
         step();
         finish[1] = 0;
      end
      chk++;
      if (done_cnt !== 4'd1) begin
         errs++; $display("FAIL wrap got %h exp 1", done_cnt);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, 7) == 0) req_tgl[c] = ~req_tgl[c];
            finish[c]  = ($urandom_range(0, 39) == 0);
            err_clr[c] = ($urandom_range(0, 29) == 0);
         end
         cfg_in = 8'($urandom);
         RST = ($urandom_range(0, 499) == 0);
         step();
         chk++;
         if (obs() !== exp_vec()) begin
            errs++; $display("FAIL random n=%0d got %h exp %h", n, obs(), exp_vec());
         end
      end
      RST = 0; finish = 0; err_clr = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_both_finish();
      test_back_to_back();
      test_rst_mid();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", chk, errs);
      $finish;
   end

endmodule
